// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // rot[j] = req[(j + s) mod 4]; the 2-bit sum wraps to give the modulo.
    function automatic logic [N_REQ-1:0] rotate_req(input logic [N_REQ-1:0] req,
                                                    input logic [ID_W-1:0]  s);
        logic [N_REQ-1:0] rot;
        logic [ID_W-1:0]  src;
        rot = {N_REQ{1'b0}};
        for (int j = 0; j < N_REQ; j++) begin
            src    = ID_W'(j) + s;
            rot[j] = req[src];
        end
        return rot;
    endfunction

    function automatic logic [ID_W-1:0] unrotate_id(input logic [ID_W-1:0] k,
                                                    input logic [ID_W-1:0] s);
        return k + s;
    endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the four clients and the arbiter.
interface rr_arbiter4_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req, done,
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, gnt_valid, timeout
    );
endinterface

// File: rtl/prio_enc4.sv
// 4-to-2 priority encoder: highest set bit wins, idx=0 and v=0 for an empty input.
module prio_enc4 (
    input  logic [3:0] x,
    output logic [1:0] idx,
    output logic       v
);

    // Fixed-priority search from bit 3 down to bit 0.
    always_comb begin
        idx = 2'd0;
        v   = 1'b0;
        if (x[3]) begin
            idx = 2'd3;
            v   = 1'b1;
        end else if (x[2]) begin
            idx = 2'd2;
            v   = 1'b1;
        end else if (x[1]) begin
            idx = 2'd1;
            v   = 1'b1;
        end else if (x[0]) begin
            idx = 2'd0;
            v   = 1'b1;
        end else begin
            idx = 2'd0;
            v   = 1'b0;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four clients with release-on-done, release-on-drop
// and a hold-time limit; always leaves one idle cycle between grants.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CW       = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter4_if.slave bus
);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    arb_state_e       state_r, state_s;
    logic [ID_W-1:0]  ptr_r, ptr_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [N_REQ-1:0] gnt_r, gnt_s;
    logic [ID_W-1:0]  gnt_id_r, gnt_id_s;
    logic             gnt_valid_r, gnt_valid_s;
    logic             timeout_r, timeout_s;

    logic [N_REQ-1:0] rot_s;
    logic [ID_W-1:0]  enc_idx_s;
    logic             enc_v_s;
    logic [ID_W-1:0]  win_id_s;

    // Rotating by the last winner puts that client at the lowest priority.
    assign rot_s    = rotate_req(bus.req, ptr_r);
    assign win_id_s = unrotate_id(enc_idx_s, ptr_r);

    prio_enc4 u_prio_enc4 (
        .x   (rot_s),
        .idx (enc_idx_s),
        .v   (enc_v_s)
    );

    // Next-state, counter, pointer and output-register values.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        cnt_s       = cnt_r;
        gnt_s       = gnt_r;
        gnt_id_s    = gnt_id_r;
        gnt_valid_s = gnt_valid_r;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (enc_v_s) begin
                    state_s     = GRANT;
                    ptr_s       = win_id_s;
                    cnt_s       = {CW{1'b0}};
                    gnt_s       = 4'b0001 << win_id_s;
                    gnt_id_s    = win_id_s;
                    gnt_valid_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                cnt_s = cnt_r + 1'b1;
                // done and request drop outrank the limit, so timeout only fires alone.
                if (bus.done || !bus.req[gnt_id_r]) begin
                    state_s     = IDLE;
                    cnt_s       = {CW{1'b0}};
                    gnt_s       = 4'b0000;
                    gnt_valid_s = 1'b0;
                end else if (cnt_r == HOLD_LAST) begin
                    state_s     = IDLE;
                    cnt_s       = {CW{1'b0}};
                    gnt_s       = 4'b0000;
                    gnt_valid_s = 1'b0;
                    timeout_s   = 1'b1;
                end else begin
                    state_s = GRANT;
                end
            end
            default: begin
                state_s     = IDLE;
                cnt_s       = {CW{1'b0}};
                gnt_s       = 4'b0000;
                gnt_valid_s = 1'b0;
            end
        endcase
    end

    // State, pointer, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= {ID_W{1'b0}};
            cnt_r       <= {CW{1'b0}};
            gnt_r       <= 4'b0000;
            gnt_id_r    <= 2'd0;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            cnt_r       <= cnt_s;
            gnt_r       <= gnt_s;
            gnt_id_r    <= gnt_id_s;
            gnt_valid_r <= gnt_valid_s;
            timeout_r   <= timeout_s;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_id    = gnt_id_r;
    assign bus.gnt_valid = gnt_valid_r;
    assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: vector table, directed corner sequences and a random
// run against a client-level reference model.
module tb_rr_arbiter4;

    localparam int HM = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rr_arbiter4_if bus ();

    rr_arbiter4 #(.HOLD_MAX(HM), .CW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] g, input logic [1:0] id,
                       input logic v, input logic t);
        n_checks++;
        if (bus.gnt !== g || bus.gnt_id !== id || bus.gnt_valid !== v || bus.timeout !== t) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b id=%0d valid=%b timeout=%b, want gnt=%b id=%0d valid=%b timeout=%b",
                     name, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout, g, id, v, t);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model state: client-level view of who owns the resource.
    int         m_owner;
    int         m_last;
    int         m_held;
    logic [1:0] m_id;
    logic       m_tmo;

    task automatic model_step(input logic [3:0] r, input logic d);
        int c;
        if (m_owner < 0) begin
            m_tmo = 1'b0;
            for (int i = 1; i <= 4; i++) begin
                c = (m_last - i + 8) % 4;
                if (m_owner < 0 && r[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_id    = 2'(c);
                    m_held  = 1;
                end
            end
        end else if (d || !r[m_owner]) begin
            m_owner = -1;
            m_tmo   = 1'b0;
        end else if (m_held == HM) begin
            m_owner = -1;
            m_tmo   = 1'b1;
        end else begin
            m_held++;
            m_tmo = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       tmp;
        int         id_i;
        logic [3:0] r_v;
        logic       d_v;
        logic [3:0] exp_g;

        // Table: idle vectors, then five grants released by done on their 3rd cycle.
        tmp = '{req: 4'b0000, done: 1'b0, gnt: 4'b0000, id: 2'd0, valid: 1'b0, tmo: 1'b0};
        vecs.push_back(tmp);
        tmp = '{req: 4'b0000, done: 1'b1, gnt: 4'b0000, id: 2'd0, valid: 1'b0, tmo: 1'b0};
        vecs.push_back(tmp);
        for (int g = 0; g < 5; g++) begin
            id_i = (3 - g + 4) % 4;
            for (int k = 0; k < 3; k++) begin
                tmp = '{req: 4'b1111, done: 1'b0, gnt: 4'b0001 << id_i, id: 2'(id_i),
                        valid: 1'b1, tmo: 1'b0};
                vecs.push_back(tmp);
            end
            tmp = '{req: 4'b1111, done: 1'b1, gnt: 4'b0000, id: 2'(id_i), valid: 1'b0, tmo: 1'b0};
            vecs.push_back(tmp);
        end

        do_reset();
        chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        foreach (vecs[i]) begin
            bus.req  = vecs[i].req;
            bus.done = vecs[i].done;
            step();
            chk($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].valid, vecs[i].tmo);
        end
        bus.done = 1'b0;

        // Single requester held past the limit.
        do_reset();
        bus.req = 4'b0001;
        for (int k = 0; k < HM; k++) begin
            step();
            chk($sformatf("hold0001_c%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step();
        chk("tmo0001", 4'b0000, 2'd0, 1'b0, 1'b1);
        step();
        chk("regrant0001", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Two requesters, timeout hands over to the next in rotation.
        do_reset();
        bus.req = 4'b0110;
        for (int k = 0; k < HM; k++) begin
            step();
            chk($sformatf("hold0110_c%0d", k), 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        step();
        chk("tmo0110", 4'b0000, 2'd2, 1'b0, 1'b1);
        step();
        chk("next0110", 4'b0010, 2'd1, 1'b1, 1'b0);

        // done coinciding with the last allowed cycle.
        do_reset();
        bus.req = 4'b0001;
        step();
        for (int k = 0; k < HM - 1; k++) step();
        chk("last_cycle", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus.done = 1'b1;
        step();
        chk("done_at_limit", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.done = 1'b0;

        // Owner drops its request while others wait.
        do_reset();
        bus.req = 4'b1111;
        step();
        chk("drop_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        step();
        bus.req = 4'b0111;
        step();
        chk("drop_release", 4'b0000, 2'd3, 1'b0, 1'b0);
        step();
        chk("drop_next", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Asynchronous reset during a grant.
        do_reset();
        bus.req = 4'b0010;
        step();
        chk("pre_reset", 4'b0010, 2'd1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_reset", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Random run against the reference model.
        do_reset();
        m_owner = -1;
        m_last  = 0;
        m_held  = 0;
        m_id    = 2'd0;
        m_tmo   = 1'b0;
        r_v     = 4'b0000;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) r_v = 4'($urandom_range(0, 15));
            d_v      = ($urandom_range(0, 9) == 0);
            bus.req  = r_v;
            bus.done = d_v;
            step();
            model_step(r_v, d_v);
            exp_g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
            chk($sformatf("rand%0d", n), exp_g, m_id, (m_owner >= 0), m_tmo);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Round-robin arbiter that shares one downstream resource between four requesters. A 4-to-2 highest-priority encoder picks the winner from a rotated request vector. An FSM holds the grant until the owner releases it or a hold-time limit expires. The block sits between the request lines of the four clients and the resource mux select, with `gnt_id` driving the mux directly.

## Interface
- `HOLD_MAX`, default 16: maximum number of consecutive cycles one grant may stay asserted (≥2).
- `CW`, default 4: hold counter width; must satisfy 2^CW ≥ HOLD_MAX.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req` input 4: request per client, level-sensitive; bit i belongs to client i.
- `done` input 1: the current owner pulses it for one cycle to release the grant.
- `gnt` output 4: one-hot grant, registered; all zeros when nothing is granted.
- `gnt_id` output 2: binary index of the granted client, registered; only meaningful while `gnt_valid`=1.
- `gnt_valid` output 1: high while any grant is held; equals |`gnt`.
- `timeout` output 1: one-cycle pulse when a grant is forcibly revoked.

## Operation
- **State**
  - Two FSM states: IDLE and GRANT.
  - Pointer `ptr[1:0]` holds the last granted id.
  - Hold counter `cnt[CW-1:0]`.
- **Reset values:** state IDLE, `ptr`=0, `cnt`=0, `gnt`=0000, `gnt_id`=0, `gnt_valid`=0, `timeout`=0.
- **Priority rotation**
  - Search order after granting client s is s-1, s-2, s-3, s (mod 4). The client just served has the lowest priority.
  - Rotated vector: `rot[j] = req[(j+s) mod 4]`.
  - `prio_enc4` returns the index k of the highest set bit of `rot`, plus a valid flag.
  - Winner id = (k+s) mod 4.
  - After reset (`ptr`=0) the search order is 3, 2, 1, 0.
- **IDLE**
  - If any `req` bit is set: load `gnt`/`gnt_id` with the winner, set `gnt_valid`, set `cnt`=0, `ptr`=winner, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - Each cycle `cnt` increments.
  - Release conditions are checked in priority order:
    1. `done`=1.
    2. `req[gnt_id]`=0, i.e. the owner dropped its request.
    3. `cnt`==HOLD_MAX-1, which is a timeout.
  - On any release: next cycle `gnt`=0000, `gnt_valid`=0, state IDLE.
  - `timeout` is set to 1 for that one cycle only if cause 3 alone applies.
- Every release spends exactly one cycle with no grant before the next arbitration. This gives a guaranteed dead cycle for the resource mux.
- `done` seen in IDLE is ignored.
- Changes on non-owner `req` lines during GRANT are ignored until the next IDLE.
- `gnt_id` keeps its last value in IDLE. Consumers must qualify it with `gnt_valid`.

## Timing
- **Grant latency:** `req` sampled high in IDLE on edge n → `gnt` high after edge n. Visible in cycle n+1.
- **Release latency:** `done`, request drop or timeout sampled on edge m → `gnt`=0 in cycle m+1. The earliest new grant is visible in cycle m+2.
- **Maximum hold:** `gnt` is high for at most HOLD_MAX consecutive cycles.
- **Worst-case wait** for a continuously requesting client: 3 × (HOLD_MAX + 1) cycles.
- **Simultaneous events:** `done` together with `cnt`==HOLD_MAX-1 counts as a normal release, with `timeout`=0. A request drop together with the timeout also gives `timeout`=0.
- **Reset mid-grant:** all outputs clear immediately, without waiting for a clock edge. After reset the search order restarts at 3, 2, 1, 0.

## Structure
- **Package `arb_pkg`** holds:
  - `N_REQ`=4 and `ID_W`=2.
  - The state typedef with IDLE and GRANT.
  - A rotation helper function for the request vector and the id.
- **Sub-module `prio_enc4`**, purely combinational:
  - Input `x[3:0]`; outputs `idx[1:0]` and `v`.
  - Highest set bit wins; `v`=0 and `idx`=0 for input 0000.
- **Top level** contains the FSM, the counter, the pointer and the output registers only.

## Test plan
- Reset, then `req`=0001 held, `done` never pulsed → `gnt`=0001 and `gnt_id`=0 one cycle after the first sample. Release at the timeout on cycle 16, with `timeout`=1 for one cycle.
- `req`=1111 held, `done` pulsed on the 3rd cycle of each grant → grant order 3, 2, 1, 0, 3, with exactly one zero-grant cycle between grants.
- `req`=0110 held, no `done` → `gnt`=0100 for exactly 16 cycles. Then `gnt`=0000 with `timeout`=1 for one cycle. Then `gnt`=0010.
- `done` asserted in the same cycle as `cnt`==15 → grant released and `timeout` stays 0.
- Owner drops its `req` bit mid-grant while other requests are pending → `gnt`=0 next cycle, `timeout`=0, then the next client in rotation is granted.
- `rst_n` pulled low while `gnt`=0010 → `gnt`=0000 immediately. After release with `req`=1111, the first grant is 1000.
